// File: rtl/fp8_pkg.sv
// Shared fp8 format constants and divider FSM state encoding.
// Format: sign | exponent (bias 3) | mantissa with hidden leading one.
package fp8_pkg;

   localparam int unsigned EXP_W = 3;
   localparam int unsigned MAN_W = 4;
   localparam int unsigned BIAS  = 3;
   localparam int unsigned FP8_W = 1 + EXP_W + MAN_W;

   localparam int unsigned SIGN_BIT = FP8_W - 1;
   localparam int unsigned EXP_HI   = FP8_W - 2;
   localparam int unsigned EXP_LO   = MAN_W;

   localparam logic [FP8_W-2:0] MAX_MAG = 7'h7F;
   localparam logic [FP8_W-2:0] MIN_MAG = 7'h00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALIGN = 2'd1,
      DIV   = 2'd2,
      PACK  = 2'd3
   } state_e;

   // Significand with the hidden one restored.
   function automatic logic [MAN_W:0] fp8_mant(input logic [FP8_W-1:0] x);
      return {1'b1, x[MAN_W-1:0]};
   endfunction

endpackage

// File: rtl/fp8_iter_divider_if.sv
// Start/busy/done handshake and operand/result bus of the fp8 divider.
interface fp8_iter_divider_if;
   import fp8_pkg::*;

   logic             start;
   logic [FP8_W-1:0] a;
   logic [FP8_W-1:0] b;
   logic [FP8_W-1:0] out;
   logic             busy;
   logic             done;
   logic             ovf;
   logic             unf;

   modport master (
      output start, a, b,
      input  out, busy, done, ovf, unf
   );

   modport slave (
      input  start, a, b,
      output out, busy, done, ovf, unf
   );

endinterface

// File: rtl/fp8_div_step.sv
// One restoring-division iteration: compare, conditional subtract, shift left.
// Purely combinational so it can be chained for an unrolled divider.
module fp8_div_step
   import fp8_pkg::*;
(
   input  logic [MAN_W+1:0] rem_i,
   input  logic [MAN_W:0]   mb_i,
   output logic [MAN_W+1:0] rem_next_c_o,
   output logic             qbit_c_o
);

   localparam int unsigned REM_W  = MAN_W + 2;
   localparam int unsigned DIFF_W = MAN_W + 1;

   logic [DIFF_W-1:0] diff;

   // The remainder stays below 2*mb, so the difference always fits in mb's width.
   assign qbit_c_o     = (rem_i >= {1'b0, mb_i});
   assign diff         = DIFF_W'(rem_i - {1'b0, mb_i});
   assign rem_next_c_o = qbit_c_o ? {diff, 1'b0} : {rem_i[REM_W-2:0], 1'b0};

endmodule

// File: rtl/fp8_iter_divider.sv
// Sequential fp8 divider: one quotient bit per clock, truncating, with
// exponent saturation and sticky overflow/underflow flags.
module fp8_iter_divider
   import fp8_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   fp8_iter_divider_if.slave    div_if
);

   localparam int unsigned REM_W = MAN_W + 2;
   localparam int unsigned E_W   = 6;
   localparam int unsigned CNT_W = 3;
   localparam logic signed [E_W-1:0] E_MAX = E_W'((1 << EXP_W) - 1);

   state_e                  state_q, state_d;
   logic                    sign_q, sign_d;
   logic [EXP_W-1:0]        exp_a_q, exp_a_d;
   logic [EXP_W-1:0]        exp_b_q, exp_b_d;
   logic [MAN_W:0]          ma_q, ma_d;
   logic [MAN_W:0]          mb_q, mb_d;
   logic signed [E_W-1:0]   e_q, e_d;
   logic [REM_W-1:0]        rem_q, rem_d;
   logic [MAN_W-1:0]        q_q, q_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [FP8_W-1:0]        out_q, out_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    ovf_q, ovf_d;
   logic                    unf_q, unf_d;

   logic signed [E_W-1:0]   e_base;
   logic [REM_W-1:0]        step_rem;
   logic                    step_qbit;

   assign e_base = E_W'(exp_a_q) - E_W'(exp_b_q) + E_W'(BIAS);

   fp8_div_step u_step (
      .rem_i        (rem_q),
      .mb_i         (mb_q),
      .rem_next_c_o (step_rem),
      .qbit_c_o     (step_qbit)
   );

   // Next-state and datapath control.
   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      exp_a_d = exp_a_q;
      exp_b_d = exp_b_q;
      ma_d    = ma_q;
      mb_d    = mb_q;
      e_d     = e_q;
      rem_d   = rem_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      ovf_d   = ovf_q;
      unf_d   = unf_q;

      case (state_q)
         IDLE: begin
            if (div_if.start) begin
               sign_d  = div_if.a[SIGN_BIT] ^ div_if.b[SIGN_BIT];
               exp_a_d = div_if.a[EXP_HI:EXP_LO];
               exp_b_d = div_if.b[EXP_HI:EXP_LO];
               ma_d    = fp8_mant(div_if.a);
               mb_d    = fp8_mant(div_if.b);
               busy_d  = 1'b1;
               state_d = ALIGN;
            end
         end

         ALIGN: begin
            // Pre-shift a smaller dividend so the leading quotient bit is always 1.
            if (ma_q < mb_q) begin
               rem_d = {ma_q, 1'b0};
               e_d   = e_base - E_W'(1);
            end else begin
               rem_d = {1'b0, ma_q};
               e_d   = e_base;
            end
            q_d     = '0;
            cnt_d   = '0;
            state_d = DIV;
         end

         DIV: begin
            rem_d = step_rem;
            q_d   = {q_q[MAN_W-2:0], step_qbit};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(MAN_W)) begin
               state_d = PACK;
            end
         end

         PACK: begin
            if (e_q > E_MAX) begin
               out_d = {sign_q, MAX_MAG};
               ovf_d = 1'b1;
               unf_d = 1'b0;
            end else if (e_q[E_W-1]) begin
               out_d = {sign_q, MIN_MAG};
               ovf_d = 1'b0;
               unf_d = 1'b1;
            end else begin
               out_d = {sign_q, e_q[EXP_W-1:0], q_q};
               ovf_d = 1'b0;
               unf_d = 1'b0;
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sign_q  <= 1'b0;
         exp_a_q <= '0;
         exp_b_q <= '0;
         ma_q    <= '0;
         mb_q    <= '0;
         e_q     <= '0;
         rem_q   <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         exp_a_q <= exp_a_d;
         exp_b_q <= exp_b_d;
         ma_q    <= ma_d;
         mb_q    <= mb_d;
         e_q     <= e_d;
         rem_q   <= rem_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign div_if.out  = out_q;
   assign div_if.busy = busy_q;
   assign div_if.done = done_q;
   assign div_if.ovf  = ovf_q;
   assign div_if.unf  = unf_q;

endmodule

// File: tb/tb_fp8_iter_divider.sv
// Directed bench for fp8_iter_divider with hand-computed expected quotients.
module tb_fp8_iter_divider;
   import fp8_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   fp8_iter_divider_if div_if ();

   fp8_iter_divider dut (
      .clk    (clk),
      .rst    (rst),
      .div_if (div_if.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns the number of edges until done is seen high, or 0 on timeout.
   task automatic wait_done(output int lat);
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (div_if.done === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_out, input logic exp_ovf, input logic exp_unf);
      int lat;
      div_if.a     = a;
      div_if.b     = b;
      div_if.start = 1'b1;
      tick();
      div_if.start = 1'b0;
      check({tag, " busy"}, div_if.busy, 1);
      wait_done(lat);
      // done rises on edge T7 after the accept edge T0 (8th clock).
      check({tag, " latency"}, lat, 7);
      check({tag, " out"}, div_if.out, exp_out);
      check({tag, " ovf"}, div_if.ovf, exp_ovf);
      check({tag, " unf"}, div_if.unf, exp_unf);
      check({tag, " busy_end"}, div_if.busy, 0);
      tick();
      check({tag, " done_pulse"}, div_if.done, 0);
      check({tag, " out_hold"}, div_if.out, exp_out);
   endtask

   initial begin
      int lat;
      int done_seen;

      rst          = 1'b1;
      div_if.start = 1'b0;
      div_if.a     = '0;
      div_if.b     = '0;
      tick();
      tick();
      check("reset out", div_if.out, 0);
      check("reset busy", div_if.busy, 0);
      check("reset done", div_if.done, 0);
      check("reset ovf", div_if.ovf, 0);
      check("reset unf", div_if.unf, 0);
      rst = 1'b0;
      tick();

      run_op("1.0/2.0", 8'h30, 8'h40, 8'h20, 1'b0, 1'b0);
      run_op("1.0/1.5", 8'h30, 8'h38, 8'h25, 1'b0, 1'b0);
      run_op("-3/2", 8'hC8, 8'h40, 8'hB8, 1'b0, 1'b0);
      run_op("-3/-2", 8'hC8, 8'hC0, 8'h38, 1'b0, 1'b0);
      run_op("ovf pos", 8'h7F, 8'h00, 8'h7F, 1'b1, 1'b0);
      run_op("ovf neg", 8'hFF, 8'h00, 8'hFF, 1'b1, 1'b0);
      run_op("unf", 8'h00, 8'h7F, 8'h00, 1'b0, 1'b1);
      tick();
      check("unf sticky", div_if.unf, 1);

      // start pulsed during DIV must be ignored.
      div_if.a     = 8'h30;
      div_if.b     = 8'h40;
      div_if.start = 1'b1;
      tick();
      div_if.start = 1'b0;
      tick();
      tick();
      tick();
      div_if.a     = 8'h7F;
      div_if.b     = 8'h00;
      div_if.start = 1'b1;
      tick();
      div_if.start = 1'b0;
      wait_done(lat);
      check("ignore latency", lat, 3);
      check("ignore out", div_if.out, 8'h20);
      check("ignore ovf", div_if.ovf, 0);
      check("ignore unf", div_if.unf, 0);
      done_seen = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (div_if.done === 1'b1) done_seen++;
      end
      check("ignore no 2nd done", done_seen, 0);

      // start held high: second op accepted on the done edge.
      div_if.a     = 8'hC8;
      div_if.b     = 8'h40;
      div_if.start = 1'b1;
      tick();
      div_if.a     = 8'h30;
      div_if.b     = 8'h38;
      wait_done(lat);
      check("b2b first latency", lat, 7);
      check("b2b first out", div_if.out, 8'hB8);
      tick();
      div_if.start = 1'b0;
      check("b2b accept busy", div_if.busy, 1);
      check("b2b accept done", div_if.done, 0);
      wait_done(lat);
      check("b2b second latency", lat, 7);
      check("b2b second out", div_if.out, 8'h25);
      tick();

      // Async reset in the 3rd DIV iteration aborts with no done.
      div_if.a     = 8'h7F;
      div_if.b     = 8'h00;
      div_if.start = 1'b1;
      tick();
      div_if.start = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("abort out", div_if.out, 0);
      check("abort busy", div_if.busy, 0);
      check("abort done", div_if.done, 0);
      check("abort ovf", div_if.ovf, 0);
      check("abort unf", div_if.unf, 0);
      tick();
      rst = 1'b0;
      done_seen = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (div_if.done === 1'b1) done_seen++;
      end
      check("abort no done", done_seen, 0);
      run_op("after reset", 8'hC8, 8'hC0, 8'h38, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
